risc_toy_ifetch: RTL and testbench

Instruction fetch unit with prefetch queue for the RISC_TOY core. It sits between the instruction memory port (IREQ/IADDR/INSTR) and the decode stage. It owns the fetch PC and issues sequential word fetches, buffering up to DEPTH fetched instructions with their PCs. It delivers them to decode over a valid/ready handshake and flushes on a branch/jump redirect from execute.

---
 rtl/risc_toy_ifetch.sv | 136 +++++++++++++
 tb/tb_risc_toy_ifetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_toy_ifetch.sv
// risc_toy_ifetch
//
// Instruction fetch unit with a prefetch queue for the RISC_TOY core.
// Owns the fetch PC, issues sequential word fetches to the instruction
// memory (fixed 1-cycle latency), buffers up to DEPTH {pc, instr} entries
// and hands them to decode over a valid/ready handshake. A redirect from
// execute flushes the queue and restarts fetch at the new PC.
//
// Parameters
//   DEPTH     queue entries, power of two in 2..16
//   RESET_PC  first fetch byte address, bits [1:0] zero
//
// Ports
//   CLK             clock, rising edge
//   RSTN            asynchronous active-low reset
//   IREQ            fetch request to instruction memory
//   IADDR[29:0]     word address of the fetch (fetch PC[31:2])
//   INSTR[31:0]     instruction word, valid the cycle after an IREQ cycle
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new byte PC (bits [1:0] ignored)
//   out_valid       queue head valid to decode
//   out_ready       decode accepts the head
//   out_instr       head instruction
//   out_pc          byte PC of the head instruction

module risc_toy_ifetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IREQ,
  output logic [29:0] IADDR,
  input  logic [31:0] INSTR,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;  // count holds 0..DEPTH
  localparam int SW = AW + 2;  // count + inflight without overflow

  // Control state
  logic [31:0]   fpc;
  logic          run;
  logic          inflight;
  logic          squash;
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [CW-1:0] count;

  // Data state (no reset needed: qualified by inflight / count)
  logic [31:0]   ipc;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];

  logic [SW-1:0] occ;
  logic          issue;
  logic          push;
  logic          pop;

  // The low two bits of a redirect target are dropped by design.
  logic          unused_rpc_lsb;
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // Issue decision uses the registered count only: a pop this cycle does
  // not open a slot until the next cycle, which keeps IREQ off the
  // out_ready path.
  always_comb begin
    occ   = SW'(count) + SW'(inflight);
    issue = run && !redirect_valid && (occ < SW'(DEPTH));
    push  = inflight && !squash && !redirect_valid;
    pop   = out_valid && out_ready;
  end

  assign IREQ      = issue;
  assign IADDR     = fpc[31:2];
  assign out_valid = (count != '0);
  // Storage is not reset, so the head is forced to zero while empty.
  assign out_pc    = out_valid ? q_pc[rd]    : '0;
  assign out_instr = out_valid ? q_instr[rd] : '0;

  // Fetch / queue control
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fpc      <= RESET_PC;
      run      <= 1'b0;
      inflight <= 1'b0;
      squash   <= 1'b0;
      rd       <= '0;
      wr       <= '0;
      count    <= '0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        // Redirect wins over issue, push and pop. A handshake in this
        // cycle still counts for decode; the queue is emptied anyway.
        fpc      <= {redirect_pc[31:2], 2'b00};
        inflight <= 1'b0;
        squash   <= inflight;
        count    <= '0;
        rd       <= wr;
      end else begin
        if (issue) begin
          fpc      <= fpc + 32'd4;
          inflight <= 1'b1;
          squash   <= 1'b0;
        end else begin
          inflight <= 1'b0;
        end
        if (push) wr <= wr + AW'(1);
        if (pop)  rd <= rd + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  // Fetch PC of the outstanding request and queue storage
  always_ff @(posedge CLK) begin
    if (issue) ipc <= fpc;
    if (push) begin
      q_pc[wr]    <= ipc;
      q_instr[wr] <= INSTR;
    end
  end

  // The issue condition reserves a slot for every outstanding fetch.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
    !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_risc_toy_ifetch.sv
// Testbench for risc_toy_ifetch: a queue-level behavioural model of the
// fetch unit plus an instruction memory returning word = byte address.
module tb_risc_toy_ifetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR = 32'hDEAD_BEEF;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  risc_toy_ifetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory: 1-cycle latency ----------------
  logic        req_s = 1'b0;
  logic [29:0] addr_s = '0;
  initial forever begin
    @(negedge CLK);
    req_s  = IREQ;
    addr_s = IADDR;
  end
  initial forever begin
    @(posedge CLK);
    #1;
    INSTR = req_s ? {addr_s, 2'b00} : 32'hDEAD_BEEF;
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_qp[$];
  logic [31:0] m_qi[$];
  logic [31:0] m_fpc = RESET_PC;
  logic [31:0] m_ipc = '0;
  bit          m_run = 0;
  bit          m_inf = 0;
  bit          m_sq  = 0;

  function automatic bit m_ireq_f();
    return m_run && !redirect_valid && ((m_qp.size() + int'(m_inf)) < DEPTH);
  endfunction

  initial forever begin
    @(posedge CLK or negedge RSTN);
    if (!RSTN) begin
      m_qp.delete(); m_qi.delete();
      m_fpc = RESET_PC; m_run = 0; m_inf = 0; m_sq = 0;
    end else begin
      bit iss, psh, hs;
      iss = m_ireq_f();
      psh = m_inf && !m_sq && !redirect_valid;
      hs  = (m_qp.size() != 0) && out_ready;
      if (redirect_valid) begin
        m_qp.delete(); m_qi.delete();
        m_sq  = m_inf;
        m_inf = 0;
        m_fpc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (hs) begin
          void'(m_qp.pop_front());
          void'(m_qi.pop_front());
        end
        if (psh) begin
          m_qp.push_back(m_ipc);
          m_qi.push_back(INSTR);
        end
        if (iss) begin
          m_ipc = m_fpc;
          m_fpc = m_fpc + 32'd4;
          m_inf = 1;
          m_sq  = 0;
        end else begin
          m_inf = 0;
        end
      end
      m_run = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  int          cyc = 0;
  logic [31:0] delivered[$];
  int          hs_cyc[$];

  initial forever begin
    @(negedge CLK);
    cyc++;
    if (!RSTN) begin
      chk("rst_ireq",      32'(IREQ),      32'h0);
      chk("rst_iaddr",     32'(IADDR),     32'(RESET_PC[31:2]));
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_pc",    out_pc,         32'h0);
      chk("rst_out_instr", out_instr,      32'h0);
    end else begin
      chk("m_out_valid", 32'(out_valid), 32'(m_qp.size() != 0));
      chk("m_ireq",      32'(IREQ),      32'(m_ireq_f()));
      chk("m_iaddr",     32'(IADDR),     32'(m_fpc[31:2]));
      if (m_qp.size() != 0) begin
        chk("m_out_pc",    out_pc,    m_qp[0]);
        chk("m_out_instr", out_instr, m_qi[0]);
      end
      if (out_valid && out_ready) begin
        delivered.push_back(out_pc);
        hs_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drv();
    @(posedge CLK);
    #1;
  endtask
  task automatic mid();
    @(negedge CLK);
  endtask

  int nd;

  initial begin
    // Reset state
    mid();
    chk("reset_ireq",      32'(IREQ),      32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_iaddr",     32'(IADDR),     32'h0);

    // Cold start with out_ready low (also the backpressure case)
    drv(); RSTN = 1'b1;                       // cycle ending at E1
    mid(); chk("cold_e1_ireq", 32'(IREQ), 32'h0);
    drv();
    mid(); chk("cold_ireq", 32'(IREQ), 32'h1); chk("cold_iaddr", 32'(IADDR), 32'h0);
    drv();
    mid(); chk("cold_iaddr1", 32'(IADDR), 32'h1); chk("cold_valid_early", 32'(out_valid), 32'h0);
    drv();
    mid(); chk("cold_valid", 32'(out_valid), 32'h1);
           chk("cold_pc", out_pc, 32'h0); chk("cold_instr", out_instr, 32'h0);
    drv();
    drv();
    mid(); chk("bp_ireq_off", 32'(IREQ), 32'h0);
    drv();
    mid(); chk("bp_ireq_off2", 32'(IREQ), 32'h0);
           chk("bp_model_depth", 32'(m_qp.size()), 32'd4);
           chk("bp_model_q3", m_qp[3], 32'hC);

    // Drain and stream
    drv(); out_ready = 1'b1;
    repeat (22) drv();
    chk("stream_len", 32'(delivered.size() >= 20), 32'h1);
    for (int i = 0; i < 20 && i < delivered.size(); i++) begin
      chk("stream_pc",  delivered[i], 32'(4 * i));
      chk("stream_gap", 32'(hs_cyc[i] - hs_cyc[0]), 32'(i));
    end

    // Redirect with 3 queued entries and one fetch in flight
    out_ready = 1'b0;
    drv(); redirect_valid = 1'b1; redirect_pc = 32'h100;
    mid(); chk("rd_pre_valid", 32'(out_valid), 32'h1); chk("rd_pre_ireq", 32'(IREQ), 32'h0);
           chk("rd_model_depth", 32'(m_qp.size()), 32'd3);
    drv(); redirect_valid = 1'b0;
    mid(); chk("rd_r1_valid", 32'(out_valid), 32'h0);
           chk("rd_r1_ireq", 32'(IREQ), 32'h1); chk("rd_r1_iaddr", 32'(IADDR), 32'h40);
    drv();
    mid(); chk("rd_r2_valid", 32'(out_valid), 32'h0);
    drv();
    mid(); chk("rd_r3_valid", 32'(out_valid), 32'h1);
           chk("rd_r3_pc", out_pc, 32'h100); chk("rd_r3_instr", out_instr, 32'h100);
    nd = delivered.size();

    // Redirect coinciding with a handshake, unaligned target
    drv(); out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h203;
    mid(); chk("rdhs_head", out_pc, 32'h100);
    drv(); redirect_valid = 1'b0;
    chk("rdhs_count", 32'(delivered.size()), 32'(nd + 1));
    if (delivered.size() > 0) chk("rdhs_pc", delivered[$], 32'h100);
    mid(); chk("rdhs_ireq", 32'(IREQ), 32'h1); chk("rdhs_iaddr", 32'(IADDR), 32'h80);
           chk("rdhs_valid", 32'(out_valid), 32'h0);
    drv();
    drv();
    mid(); chk("rdhs_new_pc", out_pc, 32'h200); chk("rdhs_new_valid", 32'(out_valid), 32'h1);

    // Address wrap
    drv(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    drv(); redirect_valid = 1'b0;
    mid(); chk("wrap_iaddr0", 32'(IADDR), 32'h3FFF_FFFF); chk("wrap_ireq0", 32'(IREQ), 32'h1);
    drv();
    mid(); chk("wrap_iaddr1", 32'(IADDR), 32'h0);
    drv();
    mid(); chk("wrap_pc0", out_pc, 32'hFFFF_FFFC); chk("wrap_instr0", out_instr, 32'hFFFF_FFFC);
    drv();
    mid(); chk("wrap_pc1", out_pc, 32'h0); chk("wrap_valid1", 32'(out_valid), 32'h1);

    // Fill the queue, then reset asynchronously mid-cycle
    drv(); out_ready = 1'b0;
    repeat (6) drv();
    mid(); chk("full_valid", 32'(out_valid), 32'h1); chk("full_ireq", 32'(IREQ), 32'h0);
    @(posedge CLK);
    #3; RSTN = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_ireq",  32'(IREQ),      32'h0);
    chk("async_iaddr", 32'(IADDR),     32'(RESET_PC[31:2]));
    drv();
    drv(); RSTN = 1'b1;
    mid(); chk("restart_e1_ireq", 32'(IREQ), 32'h0);
    drv();
    mid(); chk("restart_ireq", 32'(IREQ), 32'h1); chk("restart_iaddr", 32'(IADDR), 32'h0);
    drv();
    drv();
    mid(); chk("restart_valid", 32'(out_valid), 32'h1); chk("restart_pc", out_pc, 32'h0);
    drv();
    drv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
